pea_command_parser: RTL and testbench

- Upstream stage of the polynomial evaluator.
- Accepts a byte-serial host command stream and assembles 21-bit instructions {op[1:0], A[2:0], arg[15:0]} and 16-bit data words.
- Writes instructions into the instruction FIFO and data words into the data FIFO, in exactly the order and count the evaluator consumes them.
- Keeps a shadow "coefficient set" mask so that data belonging to commands the evaluator will reject is discarded. This keeps the data FIFO aligned.

---
 rtl/pea_pkg.sv | 55 +++++
 rtl/pea_command_parser.sv | 167 ++++++++++++++++
 tb/tb_pea_command_parser.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pea_pkg.sv
// Shared definitions for the polynomial evaluator front end: opcodes, field layout,
// FSM states and the host frame word-count rule.
package pea_pkg;

    localparam int NUM_A = 8;
    localparam int MAX_N = 10;
    localparam int MAX_B = 32;

    localparam logic [1:0] OP_RST = 2'd0;
    localparam logic [1:0] OP_STP = 2'd1;
    localparam logic [1:0] OP_EVP = 2'd2;
    localparam logic [1:0] OP_EVB = 2'd3;

    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_FRAME_ERR = 2'd1;
    localparam logic [1:0] ST_DROPPED   = 2'd2;

    localparam int OP_W    = 2;
    localparam int A_W     = 3;
    localparam int ARG_W   = 16;
    localparam int WORD_W  = 16;
    localparam int INSTR_W = OP_W + A_W + ARG_W;
    localparam int ARG_LSB = 0;
    localparam int A_LSB   = ARG_LSB + ARG_W;
    localparam int OP_LSB  = A_LSB + A_W;

    // Wide enough for the largest EVB burst (MAX_B-1 words).
    localparam int CNT_W = $clog2(MAX_B);

    localparam logic signed [ARG_W-1:0] MAX_N_S = ARG_W'(MAX_N);
    localparam logic signed [ARG_W-1:0] MAX_B_S = ARG_W'(MAX_B);

    typedef enum logic [2:0] {
        S_HDR,
        S_ARG_HI,
        S_ARG_LO,
        S_ISSUE,
        S_WORD_HI,
        S_WORD_LO,
        S_PUSH
    } state_e;

    // Number of data words following a header; depends on op and signed arg only.
    function automatic logic [CNT_W-1:0] word_count(input logic [OP_W-1:0]  op,
                                                     input logic [ARG_W-1:0] arg);
        logic signed [ARG_W-1:0] s;
        s = $signed(arg);
        word_count = '0;
        if (op == OP_STP && s >= 16'sd0 && s <= MAX_N_S)
            word_count = arg[CNT_W-1:0] + CNT_W'(1);
        else if (op == OP_EVB && s >= 16'sd0 && s < MAX_B_S)
            word_count = arg[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/pea_command_parser.sv
// Byte-serial host command parser: assembles instructions and data words for the
// evaluator FIFOs, discarding data of EVB commands whose coefficient set is empty.
module pea_command_parser
    import pea_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [INSTR_W-1:0]  instr_out,
    output logic                instr_we,
    input  logic                instr_full,
    output logic [WORD_W-1:0]   data_out,
    output logic                data_we,
    input  logic                data_full,
    output logic [NUM_A-1:0]    set_mask,
    output logic                frame_err,
    output logic [15:0]         drop_count
);

    state_e               state_q, state_d;
    logic [OP_W-1:0]      op_q, op_d;
    logic [A_W-1:0]       a_q, a_d;
    logic [7:0]           arg_hi_q, arg_hi_d;
    logic [7:0]           word_hi_q, word_hi_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [WORD_W-1:0]    data_q, data_d;
    logic [CNT_W-1:0]     words_q, words_d;
    logic                 fwd_q, fwd_d;
    logic [NUM_A-1:0]     mask_q, mask_d;
    logic [15:0]          drop_q, drop_d;
    logic                 frame_err_q, frame_err_d;
    logic [CNT_W-1:0]     issue_words;
    logic                 push_exit;

    assign issue_words = word_count(op_q, instr_q[ARG_LSB +: ARG_W]);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        arg_hi_d    = arg_hi_q;
        word_hi_d   = word_hi_q;
        instr_d     = instr_q;
        data_d      = data_q;
        words_d     = words_q;
        fwd_d       = fwd_q;
        mask_d      = mask_q;
        drop_d      = drop_q;
        frame_err_d = 1'b0;
        in_ready    = 1'b0;
        instr_we    = 1'b0;
        data_we     = 1'b0;
        push_exit   = 1'b0;

        case (state_q)
            S_HDR: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data[2:0] != 3'd0) begin
                        frame_err_d = 1'b1;
                    end else begin
                        op_d    = in_data[7:6];
                        a_d     = in_data[5:3];
                        state_d = S_ARG_HI;
                    end
                end
            end
            S_ARG_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    arg_hi_d = in_data;
                    state_d  = S_ARG_LO;
                end
            end
            S_ARG_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    instr_d = {op_q, a_q, arg_hi_q, in_data};
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!instr_full) begin
                    instr_we = 1'b1;
                    words_d  = issue_words;
                    // Decide forwarding against the mask as the evaluator will see it.
                    fwd_d    = !(op_q == OP_EVB && !mask_q[a_q]);
                    if (op_q == OP_RST)
                        mask_d = '0;
                    else if (op_q == OP_STP && issue_words != '0)
                        mask_d[a_q] = 1'b1;
                    state_d = (issue_words != '0) ? S_WORD_HI : S_HDR;
                end
            end
            S_WORD_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_hi_d = in_data;
                    state_d   = S_WORD_LO;
                end
            end
            S_WORD_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = {word_hi_q, in_data};
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                if (fwd_q) begin
                    if (!data_full) begin
                        data_we   = 1'b1;
                        push_exit = 1'b1;
                    end
                end else begin
                    push_exit = 1'b1;
                    if (drop_q != 16'hFFFF)
                        drop_d = drop_q + 16'd1;
                end
                if (push_exit) begin
                    words_d = words_q - CNT_W'(1);
                    state_d = (words_q == CNT_W'(1)) ? S_HDR : S_WORD_HI;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_HDR;
            op_q        <= '0;
            a_q         <= '0;
            arg_hi_q    <= '0;
            word_hi_q   <= '0;
            instr_q     <= '0;
            data_q      <= '0;
            words_q     <= '0;
            fwd_q       <= 1'b0;
            mask_q      <= '0;
            drop_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            arg_hi_q    <= arg_hi_d;
            word_hi_q   <= word_hi_d;
            instr_q     <= instr_d;
            data_q      <= data_d;
            words_q     <= words_d;
            fwd_q       <= fwd_d;
            mask_q      <= mask_d;
            drop_q      <= drop_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign instr_out  = instr_q;
    assign data_out   = data_q;
    assign set_mask   = mask_q;
    assign frame_err  = frame_err_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_pea_command_parser.sv
// Scoreboard bench for pea_command_parser: directed frames plus randomized frames
// against a frame-level reference model.
module tb_pea_command_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [20:0] instr_out;
    logic        instr_we;
    logic        instr_full = 1'b0;
    logic [15:0] data_out;
    logic        data_we;
    logic        data_full = 1'b0;
    logic [7:0]  set_mask;
    logic        frame_err;
    logic [15:0] drop_count;

    pea_command_parser dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr_out  (instr_out),
        .instr_we   (instr_we),
        .instr_full (instr_full),
        .data_out   (data_out),
        .data_we    (data_we),
        .data_full  (data_full),
        .set_mask   (set_mask),
        .frame_err  (frame_err),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [20:0] exp_instr[$];
    logic [15:0] exp_data[$];
    logic [15:0] wbuf[$];
    logic [7:0]  m_mask = '0;
    int          m_drop = 0;
    int          m_ferr = 0;
    int          seen_ferr = 0;

    bit          rand_full = 1'b0;
    logic        instr_full_force = 1'b0;
    logic        data_full_force = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Single driver of the FIFO full flags, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_full) begin
                instr_full = ($urandom_range(0, 9) < 3);
                data_full  = ($urandom_range(0, 9) < 3);
            end else begin
                instr_full = instr_full_force;
                data_full  = data_full_force;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT writes a FIFO.
    always @(negedge clk) begin
        if (reset) begin
            if (instr_we) begin
                if (exp_instr.size() == 0) check("instr_unexpected", {11'd0, instr_out}, 32'hDEAD);
                else check("instr", {11'd0, instr_out}, {11'd0, exp_instr.pop_front()});
            end
            if (data_we) begin
                if (exp_data.size() == 0) check("data_unexpected", {16'd0, data_out}, 32'hDEAD);
                else check("data", {16'd0, data_out}, {16'd0, exp_data.pop_front()});
            end
            if (frame_err) seen_ferr++;
        end
    end

    function automatic int model_w(input logic [1:0] op, input logic [15:0] arg);
        int s;
        s = int'($signed(arg));
        if (op == 2'd1) return (s >= 0 && s <= 10) ? s + 1 : 0;
        if (op == 2'd3) return (s >= 0 && s < 32) ? s : 0;
        return 0;
    endfunction

    // Called just after a rising edge; returns just after the edge that took the byte.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (!in_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 2000) begin
                $display("FAIL in_ready_timeout: got 0 expected 1");
                $fatal(1, "in_ready stuck low");
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom_range(0, 255);
    endtask

    task automatic gap(input int maxg);
        repeat ($urandom_range(0, maxg)) begin @(posedge clk); #1; end
    endtask

    // Model the whole frame first, then stream its bytes; words come from wbuf, padded randomly.
    task automatic send_frame(input logic [1:0] op, input logic [2:0] a,
                              input logic [15:0] arg, input int maxg);
        int w;
        logic [15:0] word;
        bit fwd;
        w = model_w(op, arg);
        exp_instr.push_back({op, a, arg});
        fwd = !(op == 2'd3 && !m_mask[a]);
        if (op == 2'd0) m_mask = '0;
        else if (op == 2'd1 && w > 0) m_mask[a] = 1'b1;
        send_byte({op, a, 3'b000}); gap(maxg);
        send_byte(arg[15:8]);       gap(maxg);
        send_byte(arg[7:0]);        gap(maxg);
        for (int i = 0; i < w; i++) begin
            word = (wbuf.size() > 0) ? wbuf.pop_front() : 16'($urandom());
            if (fwd) exp_data.push_back(word);
            else if (m_drop < 65535) m_drop++;
            send_byte(word[15:8]); gap(maxg);
            send_byte(word[7:0]);  gap(maxg);
        end
        wbuf.delete();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_instr.size() != 0 || exp_data.size() != 0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) check("drain_timeout", exp_instr.size() + exp_data.size(), 0);
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        exp_instr.delete();
        exp_data.delete();
        m_mask = '0;
        m_drop = 0;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [15:0] arg_r;
    logic [1:0]  op_r;
    logic [2:0]  a_r;

    initial begin
        do_reset();
        check("rst_in_ready",   {31'd0, in_ready}, 1);
        check("rst_instr_we",   {31'd0, instr_we}, 0);
        check("rst_data_we",    {31'd0, data_we}, 0);
        check("rst_instr_out",  {11'd0, instr_out}, 0);
        check("rst_set_mask",   {24'd0, set_mask}, 0);
        check("rst_drop_count", {16'd0, drop_count}, 0);

        // STP A=0 n=2 then EVB A=0 b=2
        wbuf = '{16'd1, 16'd2, 16'd3};
        send_frame(2'd1, 3'd0, 16'd2, 0);
        drain();
        check("stp_mask", {24'd0, set_mask}, 32'h01);
        wbuf = '{16'd5, 16'd7};
        send_frame(2'd3, 3'd0, 16'd2, 0);
        drain();
        check("evb_drop", {16'd0, drop_count}, 0);

        // EVB on an unset vector: words discarded
        do_reset();
        wbuf = '{16'd9};
        send_frame(2'd3, 3'd1, 16'd1, 0);
        drain();
        check("evb_unset_drop", {16'd0, drop_count}, 1);
        check("evb_unset_ready", {31'd0, in_ready}, 1);

        // Out-of-range STP takes no words and sets no mask bit
        send_frame(2'd1, 3'd1, 16'd11, 0);
        send_frame(2'd2, 3'd0, 16'd4, 0);
        drain();
        check("stp_bad_mask", {24'd0, set_mask}, 0);

        // arg = -1 gives no words for STP or EVB
        send_frame(2'd1, 3'd2, 16'hFFFF, 0);
        send_frame(2'd3, 3'd2, 16'hFFFF, 0);
        drain();
        check("neg_arg_mask", {24'd0, set_mask}, 0);

        // Instruction FIFO full during ISSUE
        instr_full_force = 1'b1;
        @(posedge clk); #1;
        exp_instr.push_back({2'd2, 3'd5, 16'h1234});
        send_byte(8'hA8);
        send_byte(8'h12);
        send_byte(8'h34);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 0);
            check("stall_instr_we", {31'd0, instr_we}, 0);
            check("stall_instr_out", {11'd0, instr_out}, {11'd0, 2'd2, 3'd5, 16'h1234});
        end
        @(posedge clk); #1;
        instr_full_force = 1'b0;
        drain();
        check("stall_released", exp_instr.size(), 0);

        // Bad header then RST
        send_frame(2'd1, 3'd4, 16'd0, 0);
        drain();
        check("pre_rst_mask", {24'd0, set_mask}, 32'h10);
        send_byte(8'h05);
        check("frame_err_pulse", {31'd0, frame_err}, 1);
        m_ferr++;
        @(posedge clk); #1;
        check("frame_err_clear", {31'd0, frame_err}, 0);
        send_frame(2'd0, 3'd0, 16'd0, 0);
        drain();
        check("rst_cmd_mask", {24'd0, set_mask}, 0);

        // Reset while waiting for a word's low byte
        exp_instr.push_back({2'd1, 3'd3, 16'd1});
        send_byte(8'h58);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAB);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        check("mid_rst_instr_we",  {31'd0, instr_we}, 0);
        check("mid_rst_data_we",   {31'd0, data_we}, 0);
        check("mid_rst_instr_out", {11'd0, instr_out}, 0);
        check("mid_rst_data_out",  {16'd0, data_out}, 0);
        check("mid_rst_mask",      {24'd0, set_mask}, 0);
        check("mid_rst_ferr",      {31'd0, frame_err}, 0);
        do_reset();
        check("mid_rst_in_ready",  {31'd0, in_ready}, 1);

        // Randomized frames with random host gaps and FIFO back-pressure
        rand_full = 1'b1;
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                send_byte(8'($urandom_range(0, 255)) | 8'h01);
                m_ferr++;
            end
            op_r = 2'($urandom_range(0, 3));
            a_r  = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: arg_r = 16'hFFFF;
                1: arg_r = 16'($urandom_range(0, 12));
                2: arg_r = 16'($urandom_range(29, 33));
                3: arg_r = 16'($urandom_range(0, 6));
                default: arg_r = 16'($urandom());
            endcase
            send_frame(op_r, a_r, arg_r, 2);
        end
        rand_full = 1'b0;
        drain();
        check("rand_mask", {24'd0, set_mask}, {24'd0, m_mask});
        check("rand_drop", {16'd0, drop_count}, m_drop);
        check("frame_err_count", seen_ferr, m_ferr);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
